// File: rtl/mouse_master_sm.sv
// PS/2 mouse master FSM: runs the reset/enable handshake with the mouse, then
// assembles 3-byte movement packets and publishes them with a one-cycle interrupt.
module mouse_master_sm #(
  parameter int unsigned INIT_WAIT = 1_000_000,
  parameter int unsigned TIMEOUT   = 50_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic       SEND_INTERRUPT,
  output logic [3:0] MASTER_STATE
);

  typedef enum logic [3:0] {
    StInit     = 4'd0,
    StSendFf   = 4'd1,
    StWaitTxFf = 4'd2,
    StAck1     = 4'd3,
    StBat      = 4'd4,
    StId       = 4'd5,
    StSendF4   = 4'd6,
    StWaitTxF4 = 4'd7,
    StAck2     = 4'd8,
    StRxStat   = 4'd9,
    StRxDx     = 4'd10,
    StRxDy     = 4'd11,
    StPublish  = 4'd12
  } state_e;

  localparam logic [31:0] InitLast    = 32'(INIT_WAIT - 1);
  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT - 1);

  state_e      curr_state, next_state;
  logic [31:0] curr_wait_cnt;
  logic [31:0] curr_timeout_cnt;
  logic [7:0]  curr_shadow_status, curr_shadow_dx, curr_shadow_dy;
  logic        byte_ok;
  logic        timed_out;
  logic        timed_state;
  logic        next_read_en;

  assign MASTER_STATE = curr_state;

  // Next-state decode; received-byte events win over a simultaneous timeout.
  always_comb begin
    next_state = curr_state;
    byte_ok    = BYTE_READY && (BYTE_ERROR_CODE == 2'b00);
    timed_out  = (curr_timeout_cnt == TimeoutLast);
    case (curr_state)
      StInit:     if (curr_wait_cnt == InitLast) next_state = StSendFf;
      StSendFf:   next_state = StWaitTxFf;
      StWaitTxFf: begin
        if (BYTE_SENT)      next_state = StAck1;
        else if (timed_out) next_state = StInit;
      end
      StAck1: begin
        if (BYTE_READY)     next_state = (byte_ok && BYTE_READ == 8'hFA) ? StBat : StInit;
        else if (timed_out) next_state = StInit;
      end
      StBat: begin
        if (BYTE_READY)     next_state = (byte_ok && BYTE_READ == 8'hAA) ? StId : StInit;
        else if (timed_out) next_state = StInit;
      end
      StId: begin
        if (BYTE_READY)     next_state = (byte_ok && BYTE_READ == 8'h00) ? StSendF4 : StInit;
        else if (timed_out) next_state = StInit;
      end
      StSendF4:   next_state = StWaitTxF4;
      StWaitTxF4: begin
        if (BYTE_SENT)      next_state = StAck2;
        else if (timed_out) next_state = StInit;
      end
      StAck2: begin
        if (BYTE_READY)     next_state = (byte_ok && BYTE_READ == 8'hFA) ? StRxStat : StInit;
        else if (timed_out) next_state = StInit;
      end
      // Status bytes always carry bit 3 set; anything else is a misaligned byte.
      StRxStat:   if (byte_ok && BYTE_READ[3]) next_state = StRxDx;
      StRxDx:     if (BYTE_READY) next_state = byte_ok ? StRxDy : StRxStat;
      StRxDy:     if (BYTE_READY) next_state = byte_ok ? StPublish : StRxStat;
      StPublish:  next_state = StRxStat;
      default:    next_state = StInit;
    endcase
  end

  // Classify states for the timeout counter and the receiver enable.
  always_comb begin
    timed_state  = curr_state inside {StWaitTxFf, StAck1, StBat, StId, StWaitTxF4, StAck2};
    next_read_en = next_state inside {StAck1, StBat, StId, StAck2, StRxStat, StRxDx, StRxDy};
  end

  // State, counters, shadow packet bytes and all registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      curr_state         <= StInit;
      curr_wait_cnt      <= '0;
      curr_timeout_cnt   <= '0;
      curr_shadow_status <= '0;
      curr_shadow_dx     <= '0;
      curr_shadow_dy     <= '0;
      SEND_BYTE          <= 1'b0;
      BYTE_TO_SEND       <= '0;
      READ_ENABLE        <= 1'b0;
      MOUSE_STATUS       <= '0;
      MOUSE_DX           <= '0;
      MOUSE_DY           <= '0;
      SEND_INTERRUPT     <= 1'b0;
    end else begin
      curr_state <= next_state;

      curr_wait_cnt <= (curr_state == StInit && next_state == StInit) ? curr_wait_cnt + 32'd1
                                                                      : '0;
      curr_timeout_cnt <= (timed_state && next_state == curr_state) ? curr_timeout_cnt + 32'd1
                                                                    : '0;

      if (curr_state == StRxStat && next_state == StRxDx) curr_shadow_status <= BYTE_READ;
      if (curr_state == StRxDx && next_state == StRxDy)   curr_shadow_dx     <= BYTE_READ;
      if (curr_state == StRxDy && next_state == StPublish) curr_shadow_dy    <= BYTE_READ;

      // Command byte only changes on entry to a send state, so it stays put until BYTE_SENT.
      SEND_BYTE <= (next_state == StSendFf) || (next_state == StSendF4);
      if (next_state == StSendFf) BYTE_TO_SEND <= 8'hFF;
      if (next_state == StSendF4) BYTE_TO_SEND <= 8'hF4;

      READ_ENABLE <= next_read_en;

      SEND_INTERRUPT <= (curr_state == StPublish);
      if (curr_state == StPublish) begin
        MOUSE_STATUS <= curr_shadow_status;
        MOUSE_DX     <= curr_shadow_dx;
        MOUSE_DY     <= curr_shadow_dy;
      end
    end
  end

endmodule

// File: tb/tb_mouse_master_sm.sv
// Scoreboard bench for mouse_master_sm: stimulus pushes expected transmit requests and
// packet publications; a negedge monitor pops and compares whenever the DUT emits one.
module tb_mouse_master_sm;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT = 1'b0;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ = 8'h00;
  logic [1:0] BYTE_ERROR_CODE = 2'b00;
  logic       BYTE_READY = 1'b0;
  logic [7:0] MOUSE_STATUS, MOUSE_DX, MOUSE_DY;
  logic       SEND_INTERRUPT;
  logic [3:0] MASTER_STATE;

  mouse_master_sm #(.INIT_WAIT(10), .TIMEOUT(1000)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .SEND_BYTE      (SEND_BYTE),
    .BYTE_TO_SEND   (BYTE_TO_SEND),
    .BYTE_SENT      (BYTE_SENT),
    .READ_ENABLE    (READ_ENABLE),
    .BYTE_READ      (BYTE_READ),
    .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
    .BYTE_READY     (BYTE_READY),
    .MOUSE_STATUS   (MOUSE_STATUS),
    .MOUSE_DX       (MOUSE_DX),
    .MOUSE_DY       (MOUSE_DY),
    .SEND_INTERRUPT (SEND_INTERRUPT),
    .MASTER_STATE   (MASTER_STATE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    bit          is_int;
    logic [23:0] data;
    bit          chk;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   tx_auto = 1'b1;
  bit   int_prev = 1'b0;

  task automatic push(input bit is_int, input logic [23:0] data, input bit chk, input int c);
    exp_t e;
    e.is_int = is_int;
    e.data   = data;
    e.chk    = chk;
    e.cyc    = c;
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic check_evt(input bit is_int, input logic [23:0] d);
    exp_t e;
    if (q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d data %06h at cycle %0d, expected none",
               is_int, d, cyc);
    end else begin
      e = q.pop_front();
      check(is_int ? "int_kind" : "tx_kind", 32'(is_int), 32'(e.is_int));
      check(is_int ? "packet" : "tx_byte", 32'(d), 32'(e.data));
      if (e.chk) check(is_int ? "int_cycle" : "tx_cycle", cyc, e.cyc);
    end
  endtask

  // Monitor: compare every transmit request and every published packet.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (int_prev) check("int_width", 32'(SEND_INTERRUPT), 32'd0);
      int_prev = SEND_INTERRUPT;
      if (SEND_BYTE) check_evt(1'b0, {16'h0, BYTE_TO_SEND});
      if (SEND_INTERRUPT) check_evt(1'b1, {MOUSE_STATUS, MOUSE_DX, MOUSE_DY});
    end else begin
      int_prev = 1'b0;
    end
  end

  // Transmitter model: acknowledge each request a few cycles later when enabled.
  initial begin
    forever begin
      @(negedge CLK);
      if (SEND_BYTE && tx_auto && !RESET) begin
        repeat (3) @(negedge CLK);
        BYTE_SENT = 1'b1;
        @(negedge CLK);
        BYTE_SENT = 1'b0;
      end
    end
  end

  task automatic rx(input logic [7:0] b, input logic [1:0] err, output int c);
    @(negedge CLK);
    BYTE_READ       = b;
    BYTE_ERROR_CODE = err;
    BYTE_READY      = 1'b1;
    c               = cyc;
    @(negedge CLK);
    BYTE_READY      = 1'b0;
    BYTE_ERROR_CODE = 2'b00;
  endtask

  task automatic wait_state(input logic [3:0] s, input int limit);
    int n = 0;
    while (MASTER_STATE !== s && n < limit) begin
      @(negedge CLK);
      n++;
    end
    check("wait_state", 32'(MASTER_STATE), 32'(s));
  endtask

  task automatic check_all_zero(input string name);
    check(name, {SEND_BYTE, BYTE_TO_SEND, READ_ENABLE, SEND_INTERRUPT, MASTER_STATE}, 32'd0);
    check({name, "_mouse"}, {8'h0, MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, 32'd0);
  endtask

  task automatic release_reset();
    @(negedge CLK);
    RESET = 1'b0;
    push(1'b0, 24'h0000FF, 1'b1, cyc + 10);
  endtask

  initial begin
    int c;
    int n;

    // Reset state.
    repeat (3) @(negedge CLK);
    check_all_zero("reset");

    // Init handshake.
    release_reset();
    wait_state(4'd3, 100);
    check("read_en_ack1", 32'(READ_ENABLE), 32'd1);
    rx(8'hFA, 2'b00, c);
    wait_state(4'd4, 5);
    rx(8'hAA, 2'b00, c);
    wait_state(4'd5, 5);
    push(1'b0, 24'h0000F4, 1'b0, 0);
    rx(8'h00, 2'b00, c);
    wait_state(4'd7, 5);
    check("read_en_tx", 32'(READ_ENABLE), 32'd0);
    wait_state(4'd8, 20);
    rx(8'hFA, 2'b00, c);
    wait_state(4'd9, 5);

    // Packet publish.
    rx(8'h09, 2'b00, c);
    rx(8'h05, 2'b00, c);
    rx(8'hFB, 2'b00, c);
    push(1'b1, 24'h0905FB, 1'b1, c + 2);
    repeat (5) @(negedge CLK);

    // Resync on a byte without bit 3.
    rx(8'h00, 2'b00, c);
    rx(8'h08, 2'b00, c);
    rx(8'h01, 2'b00, c);
    rx(8'h02, 2'b00, c);
    push(1'b1, 24'h080102, 1'b1, c + 2);
    repeat (5) @(negedge CLK);

    // Error on the dx byte drops the partial packet.
    rx(8'h0C, 2'b00, c);
    rx(8'h11, 2'b01, c);
    repeat (3) @(negedge CLK);
    check("err_state", 32'(MASTER_STATE), 32'd9);
    check("held_packet", {8'h0, MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, 32'h00080102);

    // Reset mid-packet.
    rx(8'h08, 2'b00, c);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check_all_zero("mid_reset");
    repeat (2) @(negedge CLK);

    // Bad acknowledge, then an unacknowledged resend that must time out.
    release_reset();
    wait_state(4'd3, 100);
    tx_auto = 1'b0;
    rx(8'hFE, 2'b00, c);
    check("bad_ack_state", 32'(MASTER_STATE), 32'd0);
    push(1'b0, 24'h0000FF, 1'b1, c + 11);
    push(1'b0, 24'h0000FF, 1'b1, c + 1022);
    wait_state(4'd2, 30);

    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    check("queue_drained", 32'(q.size()), 32'd0);
    repeat (3) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mouse_master_sm.md
Name: mouse_master_sm

Overview:
- Top-level PS/2 mouse controller FSM. Sits directly upstream of the host-to-device transmitter, driving its SEND_BYTE/BYTE_TO_SEND and consuming BYTE_SENT.
- Also consumes the device-to-host receiver's byte stream.
- Runs the reset/enable handshake (0xFF, 0xFA, 0xAA, 0x00, 0xF4, 0xFA), then assembles 3-byte movement packets and publishes them with a one-cycle interrupt.

Parameters:
- INIT_WAIT, 1_000_000: power-up idle cycles before 0xFF is sent (10 ms at 100 MHz).
- TIMEOUT, 50_000_000: max cycles spent in any single init-phase wait state before the FSM restarts.

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous active-high reset
- SEND_BYTE  out  1  one-cycle request to the transmitter
- BYTE_TO_SEND  out  8  command byte; held stable from the SEND_BYTE cycle until BYTE_SENT
- BYTE_SENT  in  1  transmitter completion pulse
- READ_ENABLE  out  1  receiver enable
- BYTE_READ  in  8  received byte, valid while BYTE_READY is high
- BYTE_ERROR_CODE  in  2  receiver error code; 00 means OK
- BYTE_READY  in  1  one-cycle received-byte strobe
- MOUSE_STATUS  out  8  last published status byte
- MOUSE_DX  out  8  last published X delta, two's complement LSBs
- MOUSE_DY  out  8  last published Y delta
- SEND_INTERRUPT  out  1  one-cycle pulse when a new packet is published
- MASTER_STATE  out  4  current state, for debug

Behaviour:
- Reset: state=INIT; all outputs 0; wait and timeout counters 0.
- Clocking: all outputs registered from curr_* regs. Single FSM with separate next-state logic. Counters are 32-bit.
- States and encoding:
  - INIT (0): count to INIT_WAIT-1, then go to SEND_FF.
  - SEND_FF (1): SEND_BYTE=1 for exactly one cycle, BYTE_TO_SEND=0xFF. Next state is WAIT_TX_FF.
  - WAIT_TX_FF (2): on BYTE_SENT go to ACK1.
  - ACK1 (3): expect 0xFA.
  - BAT (4): expect 0xAA.
  - ID (5): expect 0x00.
  - SEND_F4 (6): as SEND_FF but with 0xF4. Next state is WAIT_TX_F4 (7).
  - WAIT_TX_F4 (7): on BYTE_SENT go to ACK2.
  - ACK2 (8): expect 0xFA.
  - RX_STAT (9), RX_DX (10), RX_DY (11): collect the packet bytes.
  - PUBLISH (12): update outputs.
- Byte checks in expect states (3, 4, 5, 8), sampled on BYTE_READY:
  - BYTE_ERROR_CODE==00 and byte matches: advance.
  - Otherwise: go to INIT.
- READ_ENABLE is 1 in states 3-5 and 8-11, and 0 elsewhere, including during transmission.
- Timeout:
  - Counter clears on every state change.
  - In states 2-5, 7 and 8, reaching TIMEOUT-1 sends the FSM to INIT.
  - States 9-11 have no timeout.
- Streaming rules:
  - RX_STAT: accept BYTE_READY only if error==00 and BYTE_READ[3]==1. Otherwise stay in RX_STAT (resync).
  - RX_DX, RX_DY: latch the byte into a shadow register. Any error!=00 drops the partial packet and returns to RX_STAT.
- PUBLISH: lasts one cycle.
  - The shadow status/dx/dy registers load into MOUSE_* outputs on the clock edge leaving PUBLISH.
  - SEND_INTERRUPT is high in that same following cycle, exactly one cycle wide.
  - Next state is RX_STAT.
  - MOUSE_* outputs hold their value until the next publish.
- Latency: SEND_INTERRUPT asserts 2 cycles after the BYTE_READY that carries dy.
- Simultaneous events: BYTE_READY in a non-reading state is ignored. BYTE_SENT outside states 2 and 7 is ignored.
- Reset mid-operation: immediate return to reset values. In-flight packets are discarded and MOUSE_* are cleared.
- Illegal state codes (13-15) go to INIT.

Test Plan:
- Init handshake, with INIT_WAIT=10, TIMEOUT=1000:
  - Stimulus: BYTE_SENT after each request; reply FA, AA, 00, FA.
  - Required: SEND_BYTE pulses at cycle 11 with 0xFF, then once with 0xF4; MASTER_STATE reaches 9.
- Packet publish:
  - Stimulus: after init, send 0x09, 0x05, 0xFB.
  - Required: MOUSE_STATUS=0x09, DX=0x05, DY=0xFB; SEND_INTERRUPT high for exactly 1 cycle, 2 cycles after the third BYTE_READY.
- Resync:
  - Stimulus: bytes 0x00 (bit3=0), then 0x08, 0x01, 0x02.
  - Required: first byte discarded; publishes 08/01/02.
- Bad acknowledge:
  - Stimulus: reply 0xFE in ACK1.
  - Required: MASTER_STATE goes to 0, then 0xFF is resent after INIT_WAIT.
- Timeout:
  - Stimulus: no BYTE_SENT in state 2.
  - Required: return to INIT after 1000 cycles; SEND_BYTE fires again.
- Mid-packet error and reset:
  - Stimulus: error code 01 on the dx byte.
  - Required: back to state 9 with no interrupt.
  - Stimulus: then RESET mid-packet.
  - Required: all outputs 0, state 0.
